alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 77 +++++++
 tb/tb_alu_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with a one-entry result register; ALU_ARB_FIXED_PRIO_EN gives req0 strict priority.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req0_is_cond,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,
    input  logic            req1_is_cond,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    output logic            alu_is_cond,
    input  logic [XLEN-1:0] alu_result
);
    typedef enum logic [1:0] {EMPTY, FULL0, FULL1} state_t;
    state_t state;
    logic [XLEN-1:0] result_q;
    logic slot_free, win0, win1, acc0, acc1;
    assign slot_free = (state == EMPTY) | (state == FULL0 & rsp0_ready) | (state == FULL1 & rsp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win0 = req0_valid;
    assign win1 = req1_valid & ~req0_valid;
    assign req0_ready = slot_free;
    assign req1_ready = slot_free & ~req0_valid;
`else
    // last = requester granted most recently; the other one wins a tie
    logic last;
    assign win0 = req0_valid & (~req1_valid | last);
    assign win1 = req1_valid & (~req0_valid | ~last);
    assign req0_ready = slot_free & (~req1_valid | last);
    assign req1_ready = slot_free & (~req0_valid | ~last);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (acc0 | acc1)
            last <= acc1;
    end
`endif
    assign acc0 = req0_valid & req0_ready;
    assign acc1 = req1_valid & req1_ready;
    assign alu_a       = win0 ? req0_a       : win1 ? req1_a       : '0;
    assign alu_b       = win0 ? req0_b       : win1 ? req1_b       : '0;
    assign alu_op      = win0 ? req0_op      : win1 ? req1_op      : '0;
    assign alu_is_cond = win0 ? req0_is_cond : win1 ? req1_is_cond : 1'b0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            result_q <= '0;
        end else if (acc0 | acc1) begin
            state    <= acc0 ? FULL0 : FULL1;
            result_q <= alu_result;
        end else if (slot_free) begin
            state    <= EMPTY;
        end
    end
    assign rsp0_valid  = state == FULL0;
    assign rsp1_valid  = state == FULL1;
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model with a behavioural ALU.
module tb_alu_arbiter;
    localparam int XLEN = 32;
    localparam int OPW  = 4;
    localparam logic [OPW-1:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                               OP_XOR = 4'd4, OP_EQ = 4'd5, OP_LT = 4'd6;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid, req0_ready, req0_is_cond, req1_valid, req1_ready, req1_is_cond;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op, alu_op;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, alu_is_cond;
    logic [XLEN-1:0] rsp0_result, rsp1_result, alu_a, alu_b, alu_result;
    int n_checks = 0, n_fail = 0;
    int held, last;
    logic [XLEN-1:0] held_val;
`ifdef ALU_ARB_FIXED_PRIO_EN
    bit fixed = 1'b1;
`else
    bit fixed = 1'b0;
`endif

    alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_is_cond(req0_is_cond),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_is_cond(req1_is_cond),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_is_cond(alu_is_cond),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_ref(input logic [XLEN-1:0] a, b, input logic [OPW-1:0] op, input logic c);
        if (c)
            return {{(XLEN-1){1'b0}}, op == OP_EQ ? a == b : op == OP_LT ? $signed(a) < $signed(b) : a != b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_op, alu_is_cond);

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) return fixed ? 0 : (last == 0 ? 1 : 0);
        return v0 ? 0 : v1 ? 1 : -1;
    endfunction

    function automatic void model_reset();
        held = -1;
        last = 1;
        held_val = '0;
    endfunction

    task automatic set0(input bit v, input logic [XLEN-1:0] a, b, input logic [OPW-1:0] op, input bit c);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_is_cond = c;
    endtask

    task automatic set1(input bit v, input logic [XLEN-1:0] a, b, input logic [OPW-1:0] op, input bit c);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_is_cond = c;
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic step();
        int w;
        bit free;
        #1;
        free = held < 0 || (held == 0 && rsp0_ready) || (held == 1 && rsp1_ready);
        w = pick(req0_valid, req1_valid);
        check("req0_ready", req0_ready, free && pick(1, req1_valid) == 0);
        check("req1_ready", req1_ready, free && pick(req0_valid, 1) == 1);
        check("alu_a", alu_a, w == 0 ? req0_a : w == 1 ? req1_a : '0);
        check("alu_b", alu_b, w == 0 ? req0_b : w == 1 ? req1_b : '0);
        check("alu_op", alu_op, w == 0 ? req0_op : w == 1 ? req1_op : '0);
        check("alu_is_cond", alu_is_cond, w == 0 ? req0_is_cond : w == 1 ? req1_is_cond : 1'b0);
        @(posedge clk);
        if (free && w >= 0) begin
            held_val = w == 0 ? alu_ref(req0_a, req0_b, req0_op, req0_is_cond)
                              : alu_ref(req1_a, req1_b, req1_op, req1_is_cond);
            held = w;
            if (!fixed) last = w;
        end else if (free) begin
            held = -1;
        end
        #1;
        check("rsp0_valid", rsp0_valid, held == 0);
        check("rsp1_valid", rsp1_valid, held == 1);
        if (held == 0) check("rsp0_result", rsp0_result, held_val);
        if (held == 1) check("rsp1_result", rsp1_result, held_val);
    endtask

    initial begin
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp0_valid", rsp0_valid, 0);
        check("reset_rsp1_valid", rsp1_valid, 0);
        check("reset_result", rsp0_result, 0);
        check("reset_req0_ready", req0_ready, 1);
        check("reset_req1_ready", req1_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // single request
        set0(1, 5, 7, OP_ADD, 0);
        step();
        check("single_rsp0_valid", rsp0_valid, 1);
        check("single_rsp0_result", rsp0_result, 12);
        check("single_rsp1_valid", rsp1_valid, 0);
        // back-pressure
        set0(1, 9, 3, OP_SUB, 0);
        step();
        rsp0_ready = 1'b0;
        set0(1, 11, 1, OP_ADD, 0);
        set1(1, 22, 2, OP_ADD, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
            check("bp_result", rsp0_result, 6);
        end
        rsp0_ready = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(1, 10, 20, OP_ADD, 0);
        step();
        check("bp_release_rsp1_valid", rsp1_valid, 1);
        check("bp_release_rsp1_result", rsp1_result, 30);
        // is_cond passthrough
        set1(1, 3, 3, OP_EQ, 1);
        #1;
        check("cond_alu_is_cond", alu_is_cond, 1);
        #1;
        step();
        check("cond_rsp1_result", rsp1_result, 1);
        // reset while FULL1
        rsp1_ready = 1'b0;
        set1(1, 4, 4, OP_ADD, 0);
        step();
        set1(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rsp1_valid", rsp1_valid, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        // tie after reset: req0 first, then alternate
        set0(1, 1, 1, OP_ADD, 0);
        set1(1, 2, 2, OP_ADD, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("tie_rsp0_valid", rsp0_valid, fixed ? 1 : (i % 2 == 0));
            check("tie_result", rsp0_valid ? rsp0_result : rsp1_result, (fixed || i % 2 == 0) ? 2 : 4);
        end
        // idle
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step();
        check("idle_alu_a", alu_a, 0);
        check("idle_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        // random
        for (int i = 0; i < 400; i++) begin
            set0($urandom_range(0, 1), $urandom_range(0, 40), $urandom, 4'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            set1($urandom_range(0, 1), $urandom, $urandom_range(0, 40), 4'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            rsp0_ready = $urandom_range(0, 3) != 0;
            rsp1_ready = $urandom_range(0, 3) != 0;
            step();
            check("rsp_exclusive", rsp0_valid & rsp1_valid, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
